branch_target_buffer: RTL

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer_pkg.sv | 18 +
 rtl/branch_target_buffer_sat_counter.sv | 36 +++
 rtl/branch_target_buffer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared types for the branch target buffer: prediction-mode encodings and the
// entry record (fields sized for the widest legal configuration).
package branch_target_buffer_pkg;

  localparam int BTB_MAX_DW = 64;
  localparam int BTB_MAX_CW = 3;

  localparam int MODE_ANY_HIT = 0;
  localparam int MODE_COUNTER = 1;

  typedef struct packed {
    logic                  valid;
    logic [BTB_MAX_DW-1:0] tag;
    logic [BTB_MAX_DW-1:0] target;
    logic [BTB_MAX_CW-1:0] cnt;
  } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// Per-entry saturating direction counter; load wins over set-max, inc and dec.
module sat_counter
  import branch_target_buffer_pkg::*;
#(
  parameter int CNT_WIDTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_inc,
  input  logic                 i_dec,
  input  logic                 i_set_max,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_load_val,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load)                         cnt_d = i_load_val;
    else if (i_set_max)                 cnt_d = CNT_MAX;
    else if (i_inc && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    else if (i_dec && cnt_q != '0)      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Fully-associative BTB: zero-latency lookup, resolved-branch update with
// lowest-free / round-robin allocation, flush and saturating perf counters.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 8,
  parameter int CNT_WIDTH  = 2,
  parameter int MODE       = MODE_COUNTER
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_lookup_pc,
  input  logic                  i_lookup_valid,
  output logic                  o_hit,
  output logic                  o_predict_taken,
  output logic [DATA_WIDTH-1:0] o_predict_target,
  input  logic                  i_update_valid,
  input  logic [DATA_WIDTH-1:0] i_update_pc,
  input  logic                  i_update_uncond,
  input  logic                  i_update_taken,
  input  logic [DATA_WIDTH-1:0] i_update_target,
  input  logic                  i_flush,
  output logic [15:0]           o_hit_count,
  output logic [15:0]           o_update_count
);

  localparam int TW = DATA_WIDTH - 2;
  localparam int IW = $clog2(ENTRIES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_WEAK = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

  logic [ENTRIES-1:0]                 vld_q, vld_d;
  logic [ENTRIES-1:0][TW-1:0]         tag_q, tag_d;
  logic [ENTRIES-1:0][DATA_WIDTH-1:0] tgt_q, tgt_d;
  logic [ENTRIES-1:0][CNT_WIDTH-1:0]  cnt;
  logic [IW-1:0]                      ptr_q, ptr_d;
  logic [15:0]                        hit_cnt_q, hit_cnt_d, upd_cnt_q, upd_cnt_d;

  btb_entry_t [ENTRIES-1:0] ent;
  btb_entry_t               hit_ent;
  logic [ENTRIES-1:0]       lk_match, up_match;
  logic [ENTRIES-1:0]       c_inc, c_dec, c_max, c_load;
  logic [CNT_WIDTH-1:0]     ld_val;
  logic [TW-1:0]            lk_tag, up_tag;
  logic [IW-1:0]            free_idx, alloc_idx;
  logic                     free_found, up_tkn, do_upd, do_alloc;
  logic                     unused_bits;

  assign lk_tag = i_lookup_pc[DATA_WIDTH-1:2];
  assign up_tag = i_update_pc[DATA_WIDTH-1:2];

  // Lookup sees only registered state, so a same-cycle update is never bypassed.
  always_comb begin
    lk_match = '0;
    up_match = '0;
    hit_ent  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ent[i].valid  = vld_q[i];
      ent[i].tag    = BTB_MAX_DW'(tag_q[i]);
      ent[i].target = BTB_MAX_DW'(tgt_q[i]);
      ent[i].cnt    = BTB_MAX_CW'(cnt[i]);
      lk_match[i]   = ent[i].valid && ent[i].tag == BTB_MAX_DW'(lk_tag);
      up_match[i]   = ent[i].valid && ent[i].tag == BTB_MAX_DW'(up_tag);
    end
    for (int i = 0; i < ENTRIES; i++)
      if (lk_match[i]) hit_ent = ent[i];
  end

  assign o_hit            = i_lookup_valid && (|lk_match);
  assign o_predict_taken  = (MODE == MODE_ANY_HIT) ? o_hit : (o_hit && hit_ent.cnt[CNT_WIDTH-1]);
  assign o_predict_target = o_predict_taken ? hit_ent.target[DATA_WIDTH-1:0] : '0;
  assign unused_bits      = ^{i_lookup_pc[1:0], i_update_pc[1:0], hit_ent};

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!vld_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    alloc_idx = free_found ? free_idx : ptr_q;
    up_tkn    = i_update_taken || i_update_uncond;
    do_upd    = i_update_valid && !i_flush;
    do_alloc  = do_upd && !(|up_match) && up_tkn;
    ld_val    = i_update_uncond ? CNT_MAX : CNT_WEAK;

    vld_d  = i_flush ? '0 : vld_q;
    tag_d  = tag_q;
    tgt_d  = tgt_q;
    ptr_d  = ptr_q;
    c_inc  = '0;
    c_dec  = '0;
    c_max  = '0;
    c_load = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (do_upd && up_match[i]) begin
        if (i_update_uncond)     c_max[i] = 1'b1;
        else if (i_update_taken) c_inc[i] = 1'b1;
        else                     c_dec[i] = 1'b1;
        if (up_tkn) tgt_d[i] = i_update_target;
      end
    if (do_alloc) begin
      vld_d[alloc_idx]  = 1'b1;
      tag_d[alloc_idx]  = up_tag;
      tgt_d[alloc_idx]  = i_update_target;
      c_load[alloc_idx] = 1'b1;
      if (!free_found) ptr_d = ptr_q + 1'b1;
    end

    hit_cnt_d = (o_hit && hit_cnt_q != 16'hFFFF) ? hit_cnt_q + 16'd1 : hit_cnt_q;
    upd_cnt_d = (i_update_valid && upd_cnt_q != 16'hFFFF) ? upd_cnt_q + 16'd1 : upd_cnt_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q     <= '0;
      tag_q     <= '0;
      tgt_q     <= '0;
      ptr_q     <= '0;
      hit_cnt_q <= '0;
      upd_cnt_q <= '0;
    end else begin
      vld_q     <= vld_d;
      tag_q     <= tag_d;
      tgt_q     <= tgt_d;
      ptr_q     <= ptr_d;
      hit_cnt_q <= hit_cnt_d;
      upd_cnt_q <= upd_cnt_d;
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt [ENTRIES-1:0] (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_inc      (c_inc),
    .i_dec      (c_dec),
    .i_set_max  (c_max),
    .i_load     (c_load),
    .i_load_val (ld_val),
    .o_cnt      (cnt)
  );

  assign o_hit_count    = hit_cnt_q;
  assign o_update_count = upd_cnt_q;

endmodule
